// File: rtl/ahb_trans_fifo_if.sv
// Valid/ready handshake bundle for the AHB-Lite transfer descriptor FIFO.
// The master modport drives pushes and accepts pops; the slave modport is the FIFO itself.
interface ahb_trans_fifo_if #(
    parameter int unsigned BUS_WIDTH = 32
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_hwrite;
    logic [1:0]           in_hsize;
    logic [BUS_WIDTH-1:0] in_haddr;
    logic [BUS_WIDTH-1:0] in_hdata;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_hwrite;
    logic [1:0]           out_hsize;
    logic [BUS_WIDTH-1:0] out_haddr;
    logic [BUS_WIDTH-1:0] out_hdata;

    modport master (
        output in_valid, in_hwrite, in_hsize, in_haddr, in_hdata, out_ready,
        input  in_ready, out_valid, out_hwrite, out_hsize, out_haddr, out_hdata
    );

    modport slave (
        input  in_valid, in_hwrite, in_hsize, in_haddr, in_hdata, out_ready,
        output in_ready, out_valid, out_hwrite, out_hsize, out_haddr, out_hdata
    );
endinterface

// File: rtl/ahb_trans_fifo.sv
// First-word-fall-through FIFO of AHB-Lite transfer descriptors with flush and watermark.
// Define AHB_FIFO_ALIGN_CHECK_EN to drop misaligned pushes and pulse align_err instead.
module ahb_trans_fifo #(
    parameter int unsigned BUS_WIDTH = 32,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             HCLK,
    input  logic             resetn,
    input  logic             flush,
    ahb_trans_fifo_if.slave  bus,
    output logic [CNT_W-1:0] count,
    output logic             almost_full,
    output logic             align_err
);
    localparam int unsigned      PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);

    typedef struct packed {
        logic                 hwrite;
        logic [1:0]           hsize;
        logic [BUS_WIDTH-1:0] haddr;
        logic [BUS_WIDTH-1:0] hdata;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             empty;
    logic             push_hs;
    logic             misalign;
    logic             push;
    logic             pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign push_hs = bus.in_valid && !full;

`ifdef AHB_FIFO_ALIGN_CHECK_EN
    logic align_err_q;

    always_comb begin
        misalign = 1'b0;
        case (bus.in_hsize)
            2'b01:   misalign = bus.in_haddr[0];
            2'b10:   misalign = |bus.in_haddr[1:0];
            2'b11:   misalign = 1'b1;
            default: misalign = 1'b0;
        endcase
    end

    always_ff @(posedge HCLK or negedge resetn) begin
        if (!resetn) begin
            align_err_q <= 1'b0;
        end else if (flush) begin
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= push_hs && misalign;
        end
    end

    assign align_err = align_err_q;
`else
    assign misalign  = 1'b0;
    assign align_err = 1'b0;
`endif

    // Flush wins over both sides; a dropped misaligned push still completes its handshake.
    assign push = push_hs && !misalign && !flush;
    assign pop  = !empty && bus.out_ready && !flush;

    always_ff @(posedge HCLK or negedge resetn) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (push) begin
            mem[wr_ptr] <= '{hwrite: bus.in_hwrite, hsize: bus.in_hsize,
                             haddr: bus.in_haddr, hdata: bus.in_hdata};
        end
    end

    assign head           = mem[rd_ptr];
    assign bus.out_hwrite = head.hwrite;
    assign bus.out_hsize  = head.hsize;
    assign bus.out_haddr  = head.haddr;
    assign bus.out_hdata  = head.hdata;

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign count         = count_q;
    assign almost_full   = (count_q >= AF_CNT);
endmodule

// File: tb/tb_ahb_trans_fifo.sv
// Self-checking bench for ahb_trans_fifo: queue-based reference model plus vector table.
// Builds with or without AHB_FIFO_ALIGN_CHECK_EN.
module tb_ahb_trans_fifo;
    localparam int unsigned DEPTH = 8;

    typedef struct packed {
        logic        wr;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    typedef struct {
        ent_t e;
        int   exp_count;
    } vec_t;

    logic       HCLK = 1'b0;
    logic       resetn = 1'b0;
    logic       flush = 1'b0;
    logic [3:0] count;
    logic       almost_full;
    logic       align_err;

    int   errors = 0;
    int   checks = 0;
    ent_t sbq[$];
    logic m_align = 1'b0;

    ahb_trans_fifo_if #(.BUS_WIDTH(32)) bus ();

    ahb_trans_fifo #(
        .BUS_WIDTH(32),
        .DEPTH    (DEPTH)
    ) dut (
        .HCLK       (HCLK),
        .resetn     (resetn),
        .flush      (flush),
        .bus        (bus.slave),
        .count      (count),
        .almost_full(almost_full),
        .align_err  (align_err)
    );

    always #5 HCLK = ~HCLK;

    function automatic ent_t mk(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                                input logic [31:0] d);
        ent_t e;
        e.wr = wr;
        e.sz = sz;
        e.a  = a;
        e.d  = d;
        return e;
    endfunction

    function automatic logic mis_f(input ent_t e);
`ifdef AHB_FIFO_ALIGN_CHECK_EN
        case (e.sz)
            2'b01:   return e.a[0];
            2'b10:   return e.a[1:0] != 2'b00;
            2'b11:   return 1'b1;
            default: return 1'b0;
        endcase
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        chk("count", 64'(count), 64'(sbq.size()));
        chk("in_ready", 64'(bus.in_ready), 64'(sbq.size() < DEPTH));
        chk("out_valid", 64'(bus.out_valid), 64'(sbq.size() > 0));
        chk("almost_full", 64'(almost_full), 64'(sbq.size() >= DEPTH - 2));
        chk("align_err", 64'(align_err), 64'(m_align));
    endtask

    // One clock: drive, compare head on pop, advance model at the edge, then check state.
    task automatic cyc(input logic iv, input ent_t e, input logic ordy, input logic fl);
        logic push_hs;
        logic pop;
        logic mis;
        bus.in_valid  = iv;
        bus.in_hwrite = e.wr;
        bus.in_hsize  = e.sz;
        bus.in_haddr  = e.a;
        bus.in_hdata  = e.d;
        bus.out_ready = ordy;
        flush         = fl;
        push_hs = iv && (sbq.size() < DEPTH);
        pop     = ordy && (sbq.size() > 0);
        mis     = mis_f(e);
        if (pop && !fl) begin
            chk("pop_hwrite", 64'(bus.out_hwrite), 64'(sbq[0].wr));
            chk("pop_hsize", 64'(bus.out_hsize), 64'(sbq[0].sz));
            chk("pop_haddr", 64'(bus.out_haddr), 64'(sbq[0].a));
            chk("pop_hdata", 64'(bus.out_hdata), 64'(sbq[0].d));
        end
        @(posedge HCLK);
        if (fl) begin
            sbq.delete();
            m_align = 1'b0;
        end else begin
            if (pop) void'(sbq.pop_front());
            if (push_hs && !mis) sbq.push_back(e);
            m_align = push_hs && mis;
        end
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
        check_state();
    endtask

    vec_t vt[5];
    ent_t z;

    initial begin
        z = mk(1'b0, 2'b00, 32'h0, 32'h0);
        bus.in_valid  = 1'b0;
        bus.in_hwrite = 1'b0;
        bus.in_hsize  = 2'b00;
        bus.in_haddr  = '0;
        bus.in_hdata  = '0;
        bus.out_ready = 1'b0;

        vt[0] = '{e: mk(1'b1, 2'b01, 32'h2, 32'hFF), exp_count: 1};
        vt[1] = '{e: mk(1'b0, 2'b01, 32'h2, 32'hCC), exp_count: 2};
        vt[2] = '{e: mk(1'b1, 2'b00, 32'h2000, 32'hAA), exp_count: 3};
        vt[3] = '{e: mk(1'b0, 2'b10, 32'h4, 32'hCF), exp_count: 4};
        vt[4] = '{e: mk(1'b1, 2'b01, 32'h6, 32'hBF), exp_count: 5};

        // Reset state
        #1;
        check_state();
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        resetn = 1'b1;
        @(posedge HCLK);
        #1;
        check_state();

        // Table-driven pushes, then in-order pops
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, vt[i].e, 1'b0, 1'b0);
            chk("vec_count", 64'(count), 64'(vt[i].exp_count));
        end
        for (int i = 0; i < 5; i++) cyc(1'b0, z, 1'b1, 1'b0);
        chk("drained_out_valid", 64'(bus.out_valid), 64'd0);

        // Steady push+pop at count 3 across pointer wrap
        for (int i = 0; i < 3; i++) cyc(1'b1, mk(1'b1, 2'b10, 32'(i * 4), 32'(100 + i)), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, mk(i[0], 2'b10, 32'(32'h100 + i * 4), 32'(32'hA000 + i)), 1'b1, 1'b0);
            chk("stream_count", 64'(count), 64'd3);
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, z, 1'b1, 1'b0);

        // Fill to full; 9th push held off until a pop, accepted the cycle after
        for (int i = 0; i < 8; i++) cyc(1'b1, mk(1'b0, 2'b00, 32'(i), 32'(32'hB0 + i)), 1'b0, 1'b0);
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        repeat (2) cyc(1'b1, mk(1'b1, 2'b10, 32'h90, 32'h99), 1'b0, 1'b0);
        chk("full_hold_count", 64'(count), 64'd8);
        cyc(1'b1, mk(1'b1, 2'b10, 32'h90, 32'h99), 1'b1, 1'b0);
        chk("pop_at_full_count", 64'(count), 64'd7);
        cyc(1'b1, mk(1'b1, 2'b10, 32'h90, 32'h99), 1'b0, 1'b0);
        chk("ninth_accepted", 64'(count), 64'd8);

        // Flush at count 4 with push and pop both requested
        for (int i = 0; i < 4; i++) cyc(1'b0, z, 1'b1, 1'b0);
        cyc(1'b1, mk(1'b1, 2'b10, 32'hDEAD0, 32'hF1F1), 1'b1, 1'b1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        cyc(1'b1, mk(1'b0, 2'b00, 32'h55, 32'h66), 1'b0, 1'b0);
        cyc(1'b0, z, 1'b1, 1'b0);

        // Alignment handling
        cyc(1'b1, mk(1'b1, 2'b01, 32'h1, 32'hFF), 1'b0, 1'b0);
`ifdef AHB_FIFO_ALIGN_CHECK_EN
        chk("misalign_pulse", 64'(align_err), 64'd1);
`else
        chk("misalign_pulse", 64'(align_err), 64'd0);
`endif
        cyc(1'b1, mk(1'b1, 2'b10, 32'h4, 32'h11), 1'b0, 1'b0);
`ifdef AHB_FIFO_ALIGN_CHECK_EN
        chk("align_count", 64'(count), 64'd1);
`else
        chk("align_count", 64'(count), 64'd2);
`endif
        while (sbq.size() > 0) cyc(1'b0, z, 1'b1, 1'b0);

        // Asynchronous reset mid-stream at count 3
        for (int i = 0; i < 3; i++) cyc(1'b1, mk(1'b0, 2'b00, 32'(i), 32'(i)), 1'b0, 1'b0);
        #1;
        resetn = 1'b0;
        #1;
        chk("areset_count", 64'(count), 64'd0);
        chk("areset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("areset_in_ready", 64'(bus.in_ready), 64'd1);
        sbq.delete();
        m_align = 1'b0;
        @(negedge HCLK);
        resetn = 1'b1;
        @(posedge HCLK);
        #1;
        check_state();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
